codec_sample_serializer: RTL and testbench
==========================================

Name: codec_sample_serializer

Overview:
- Downstream stage of the music player: takes 16-bit samples from the player, buffers them in a small FIFO and shifts them out MSB-first on a serial codec link.
- Generates the codec bit clock (bclk) and word clock (lrclk).
- Emits the one-cycle frame request pulse that drives the player's NewFrame input, so the player produces exactly one sample per codec frame.
- Same sample is sent on left and right channels.

Parameters:
- CLK_DIV, 4, clk cycles per bclk half-period (>=2).
- FIFO_DEPTH, 4, sample FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- play  in  1  player running; gates requests and FIFO pops.
- sample_in  in  16  two's-complement sample from player.
- sample_valid  in  1  one-cycle strobe: push sample_in.
- new_frame  out  1  one-cycle request pulse, wired to player NewFrame.
- bclk  out  1  serial bit clock.
- lrclk  out  1  word clock: 0 = left, 1 = right.
- sdata  out  1  serial data, changes on bclk falling edge.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun  out  1  one-cycle pulse: pop attempted on empty FIFO while play=1.
- overflow  out  1  one-cycle pulse: push attempted while full; sample dropped.

Behaviour:
- Reset (async assert, sync release): bclk=0, lrclk=0, sdata=0, new_frame=0, underrun=0, overflow=0, FIFO empty (fifo_level=0), divider=0, bit counter=31, shift register=0.
- Divider:
  - Counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and bclk toggles.
  - A bclk 1->0 toggle is a "fall event".
  - Frame = 32 bclk periods = 64*CLK_DIV clk cycles.
- Bit counter:
  - Increments (mod 32) on each fall event.
  - lrclk = bitcnt[4], registered with the fall event.
  - The first fall event after reset wraps 31->0 and starts frame 0.
- Frame start (fall event where bitcnt 31->0):
  - play=1, FIFO non-empty: pop the head; load the shift register with the popped sample; latch it as the current sample.
  - play=1, FIFO empty: load 0 and pulse underrun.
  - play=0: load 0; no pop, no underrun.
  - new_frame pulses high for exactly one clk on this cycle iff play=1.
- Right channel (fall event where bitcnt 15->16): reload the shift register with the current sample (0 if the frame started empty or with play=0).
- Other fall events: shift left by 1, filling with 0.
- sdata = shift register bit 15, so sdata updates in the same clk as the fall event.
- Push: sample_valid=1 and not full -> write at tail. Full -> drop and pulse overflow.
- Simultaneous push and pop:
  - The pop uses pre-cycle state; there is no bypass.
  - When empty, the pop underruns and the push is stored; level becomes 1.
  - When full, both succeed; level stays FIFO_DEPTH and there is no overflow.
- Pointers wrap mod FIFO_DEPTH. fifo_level is registered and reflects pushes and pops from the previous clk.
- play=0 retains FIFO contents; no flush.
- Reset mid-frame: all state returns to reset values immediately, and frame timing restarts from bitcnt=31.

Optional Feature:
- Macro SERIALIZER_VOLUME_EN.
- Defined:
  - Adds input port vol (3 bits).
  - The sample loaded at frame start is arithmetic-shifted right by vol (sign-extended), e.g. vol=2: 16'h8000 -> 16'hE000.
  - vol is sampled only at frame start; the right channel reuses the same shifted value.
- Undefined:
  - No vol port.
  - Samples are serialized unmodified.

Test Plan:
- Reset release, CLK_DIV=2, play=1, empty FIFO -> first fall event at clk 4 after release: new_frame=1 and underrun=1 in that cycle; sdata=0 for all 32 bits; next frame start 128 clks later.
- Push 16'hA5C3 before a frame start, play=1 -> left bits MSB-first 1010010111000011, right channel identical; lrclk goes 0->1 after 16 bclk falls; fifo_level 1->0 at frame start.
- Push 5 samples back-to-back, FIFO_DEPTH=4 -> fifo_level reaches 4, overflow pulses once on the 5th push, and the first 4 samples serialize in order in the following frames.
- FIFO full, push coincident with frame-start pop -> fifo_level stays 4, no overflow, popped sample is the oldest entry.
- play=0 for 3 frames with 2 samples queued -> no new_frame, no underrun, sdata=0, fifo_level stays 2; play=1 -> next frame outputs the first queued sample.
- Assert reset at bitcnt=20 -> outputs return to reset values asynchronously, FIFO empties, and after release the frame restarts with the first fall event at clk 2*CLK_DIV.

Source files
------------

// File: rtl/codec_sample_serializer.sv
// Sample FIFO plus MSB-first serial codec link with generated bclk/lrclk and per-frame request pulse.
// Optional macro SERIALIZER_VOLUME_EN adds a 3-bit vol input that arithmetic-shifts each frame's sample.
module codec_sample_serializer #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned AW        = $clog2(FIFO_DEPTH),
   localparam int unsigned LW        = AW + 1,
   localparam int unsigned DIVW      = $clog2(CLK_DIV)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          play,
   input  logic [15:0]   sample_in,
   input  logic          sample_valid,
`ifdef SERIALIZER_VOLUME_EN
   input  logic [2:0]    vol,
`endif
   output logic          new_frame,
   output logic          bclk,
   output logic          lrclk,
   output logic          sdata,
   output logic [LW-1:0] fifo_level,
   output logic          underrun,
   output logic          overflow
);

   logic [DIVW-1:0] div_q, div_d;
   logic            bclk_q, bclk_d;
   logic [4:0]      bitcnt_q, bitcnt_d;
   logic            lrclk_q, lrclk_d;
   logic [15:0]     shift_q, shift_d;
   logic [15:0]     cur_q, cur_d;
   logic            new_frame_q, new_frame_d;
   logic            underrun_q, underrun_d;
   logic            overflow_q, overflow_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [AW-1:0]   wr_q, wr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [15:0]     mem_q [FIFO_DEPTH];

   logic            div_wrap, fall_evt, frame_start, right_start;
   logic            fifo_empty, fifo_full, pop_req, pop_ok, push_ok;
   logic [15:0]     head, scaled, loaded;

   assign div_wrap    = (div_q == DIVW'(CLK_DIV - 1));
   assign fall_evt    = div_wrap & bclk_q;
   assign frame_start = fall_evt & (bitcnt_q == 5'd31);
   assign right_start = fall_evt & (bitcnt_q == 5'd15);

   assign fifo_empty  = (level_q == '0);
   assign fifo_full   = (level_q == LW'(FIFO_DEPTH));
   assign pop_req     = frame_start & play;
   assign pop_ok      = pop_req & ~fifo_empty;
   // A pop on a full FIFO frees a slot in the same cycle, so a coincident push is kept.
   assign push_ok     = sample_valid & (~fifo_full | pop_ok);

   assign head = mem_q[rd_q];
`ifdef SERIALIZER_VOLUME_EN
   assign scaled = 16'($signed(head) >>> vol);
`else
   assign scaled = head;
`endif
   assign loaded = pop_ok ? scaled : 16'h0000;

   always_comb begin
      div_d       = div_wrap ? '0 : div_q + 1'b1;
      bclk_d      = bclk_q ^ div_wrap;
      bitcnt_d    = bitcnt_q;
      lrclk_d     = lrclk_q;
      shift_d     = shift_q;
      cur_d       = cur_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      level_d     = level_q;
      new_frame_d = pop_req;
      underrun_d  = pop_req & fifo_empty;
      overflow_d  = sample_valid & ~push_ok;

      if (fall_evt) begin
         bitcnt_d = bitcnt_q + 5'd1;
         lrclk_d  = bitcnt_d[4];
         if (frame_start) begin
            shift_d = loaded;
            cur_d   = loaded;
         end else if (right_start) begin
            shift_d = cur_q;
         end else begin
            shift_d = {shift_q[14:0], 1'b0};
         end
      end

      if (pop_ok)  rd_d = rd_q + 1'b1;
      if (push_ok) wr_d = wr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q       <= '0;
         bclk_q      <= 1'b0;
         bitcnt_q    <= 5'd31;
         lrclk_q     <= 1'b0;
         shift_q     <= '0;
         cur_q       <= '0;
         new_frame_q <= 1'b0;
         underrun_q  <= 1'b0;
         overflow_q  <= 1'b0;
         rd_q        <= '0;
         wr_q        <= '0;
         level_q     <= '0;
      end else begin
         div_q       <= div_d;
         bclk_q      <= bclk_d;
         bitcnt_q    <= bitcnt_d;
         lrclk_q     <= lrclk_d;
         shift_q     <= shift_d;
         cur_q       <= cur_d;
         new_frame_q <= new_frame_d;
         underrun_q  <= underrun_d;
         overflow_q  <= overflow_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         level_q     <= level_d;
      end
   end

   // Storage needs no reset: entries are only read while the occupancy says they are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= sample_in;
   end

   assign new_frame  = new_frame_q;
   assign bclk       = bclk_q;
   assign lrclk      = lrclk_q;
   assign sdata      = shift_q[15];
   assign fifo_level = level_q;
   assign underrun   = underrun_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_codec_sample_serializer.sv
// Scoreboard bench for codec_sample_serializer: cycle-count reference model, serial-word monitor.
module tb_codec_sample_serializer;
   localparam int CLK_DIV    = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int LW         = $clog2(FIFO_DEPTH) + 1;
   localparam int FRAME      = 64 * CLK_DIV;
   localparam int FALL       = 2 * CLK_DIV;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          play = 1'b0;
   logic [15:0]   sample_in = '0;
   logic          sample_valid = 1'b0;
`ifdef SERIALIZER_VOLUME_EN
   logic [2:0]    vol = '0;
`endif
   logic          new_frame, bclk, lrclk, sdata, underrun, overflow;
   logic [LW-1:0] fifo_level;

   codec_sample_serializer #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk          (clk),
      .reset        (rst_n),
      .play         (play),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
`ifdef SERIALIZER_VOLUME_EN
      .vol          (vol),
`endif
      .new_frame    (new_frame),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .sdata        (sdata),
      .fifo_level   (fifo_level),
      .underrun     (underrun),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: everything derives from n, the number of clk edges since reset release.
   int          n;
   logic [15:0] model_fifo[$];
   logic [15:0] exp_q[$];
   logic        exp_bclk, exp_lrclk, exp_new_frame, exp_underrun, exp_overflow;
   logic [LW-1:0] exp_level;

   always @(posedge clk or negedge rst_n) begin
      int m, pre;
      logic popped;
      logic [15:0] word;
      logic signed [15:0] sword;
      if (!rst_n) begin
         n = 0;
         model_fifo.delete();
         exp_q.delete();
         exp_bclk = 0; exp_lrclk = 0; exp_new_frame = 0;
         exp_underrun = 0; exp_overflow = 0; exp_level = '0;
      end else begin
         n++;
         exp_new_frame = 0; exp_underrun = 0; exp_overflow = 0;
         exp_bclk  = ((n / CLK_DIV) % 2) == 1;
         m         = n / FALL;
         exp_lrclk = (m >= 1) && (((m - 1) % 32) >= 16);
         pre       = model_fifo.size();
         popped    = 0;
         if ((n % FALL) == 0 && ((m - 1) % 32) == 0) begin
            word = 16'h0000;
            if (play) begin
               exp_new_frame = 1;
               if (pre > 0) begin
                  word   = model_fifo.pop_front();
                  popped = 1;
`ifdef SERIALIZER_VOLUME_EN
                  sword = word;
                  word  = sword >>> vol;
`endif
               end else begin
                  exp_underrun = 1;
               end
            end
            exp_q.push_back(word);
            exp_q.push_back(word);
         end
         if (sample_valid) begin
            if (pre < FIFO_DEPTH || popped) model_fifo.push_back(sample_in);
            else exp_overflow = 1;
         end
         exp_level = LW'(model_fifo.size());
      end
   end

   // Monitor: per-cycle control checks, and a 16-bit serial word collected on every bclk fall.
   logic        prev_bclk = 1'b0;
   int          nbits = 0;
   logic [15:0] acc = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_bclk = 0;
         nbits = 0;
         acc = '0;
      end else begin
         check("bclk", 32'(bclk), 32'(exp_bclk));
         check("lrclk", 32'(lrclk), 32'(exp_lrclk));
         check("new_frame", 32'(new_frame), 32'(exp_new_frame));
         check("underrun", 32'(underrun), 32'(exp_underrun));
         check("overflow", 32'(overflow), 32'(exp_overflow));
         check("fifo_level", 32'(fifo_level), 32'(exp_level));
         if (prev_bclk && !bclk) begin
            acc = {acc[14:0], sdata};
            nbits++;
            if (nbits == 16) begin
               nbits = 0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL serial_word: got %0h expected none queued at %0t", acc, $time);
               end else begin
                  check("serial_word", 32'(acc), 32'(exp_q.pop_front()));
               end
            end
         end
         prev_bclk = bclk;
      end
   end

   task automatic push(input logic [15:0] v);
      sample_in    = v;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic run_frames(input int f);
      repeat (f * FRAME) @(negedge clk);
   endtask

   // Stops right after the edge whose offset from the first frame start equals off.
   task automatic wait_offset(input int off);
      logic found = 0;
      for (int k = 0; k < 2 * FRAME && !found; k++) begin
         @(negedge clk);
         if (n >= FALL && ((n - FALL) % FRAME) == off) found = 1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL wait_offset: got timeout expected offset %0d", off);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bclk"}, 32'(bclk), 32'd0);
      check({tag, "_lrclk"}, 32'(lrclk), 32'd0);
      check({tag, "_sdata"}, 32'(sdata), 32'd0);
      check({tag, "_new_frame"}, 32'(new_frame), 32'd0);
      check({tag, "_underrun"}, 32'(underrun), 32'd0);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
      check({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      play  = 1'b1;
      repeat (FALL) @(negedge clk);
      check("first_new_frame", 32'(new_frame), 32'd1);
      check("first_underrun", 32'(underrun), 32'd1);
      run_frames(2);

      // Single known pattern, then five back-to-back pushes into a four-deep FIFO.
      wait_offset(10);
      push(16'hA5C3);
      run_frames(2);
      wait_offset(10);
      for (int i = 0; i < 5; i++) push(16'h1111 * 16'(i + 1));
      check("overflow_5th", 32'(overflow), 32'd1);
      run_frames(5);

      // Full FIFO with a push landing on the frame-start pop.
      wait_offset(10);
      for (int i = 0; i < 4; i++) push(16'h8001 + 16'(i));
      wait_offset(FRAME - 1);
      push(16'h7E57);
      check("full_coincident_level", 32'(fifo_level), 32'(FIFO_DEPTH));
      check("full_coincident_no_overflow", 32'(overflow), 32'd0);
      run_frames(6);

      // Paused player keeps its queue.
      wait_offset(10);
      play = 1'b0;
      push(16'h0F0F);
      push(16'hF00D);
      run_frames(3);
      check("paused_level", 32'(fifo_level), 32'd2);
      play = 1'b1;
      run_frames(3);

      // Random traffic and random play toggling.
      for (int c = 0; c < 12 * FRAME; c++) begin
         sample_in    = 16'($urandom);
         sample_valid = ($urandom_range(0, 99) < 2);
`ifdef SERIALIZER_VOLUME_EN
         vol = 3'($urandom_range(0, 7));
`endif
         if ($urandom_range(0, 299) == 0) play = ~play;
         @(negedge clk);
      end
      sample_valid = 1'b0;
      play = 1'b1;

      // Reset asserted mid-frame at bitcnt 20.
      wait_offset(10);
      push(16'h1357);
      push(16'h2468);
      wait_offset(20 * FALL);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (FALL) @(negedge clk);
      check("restart_new_frame", 32'(new_frame), 32'd1);
      push(16'hC0DE);
      run_frames(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
